// File: rtl/trng_ctrl.sv
// trng_ctrl: warm-up, sampling, word packing and repetition-count
// health test in front of trng_core, with a valid/ready word port.
module trng_ctrl #(
  parameter int WORD_W     = 32,
  parameter int WARMUP_CYC = 64,
  parameter int RCT_LIMIT  = 16,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_fail,
  output logic              trng_en,
  input  logic              rnd_bit,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  localparam int DW = $clog2(SAMPLE_DIV + 1);

  typedef enum logic [2:0] {
    IDLE, WARMUP, COLLECT, HOLD, FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     warm_q, warm_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [RW-1:0]     run_q, run_d;
  logic [DW-1:0]     div_q, div_d;
  logic              last_q, last_d;
  logic [WORD_W-2:0] part_q, part_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              stop_seen_q, stop_seen_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              fail_q, fail_d;

  logic [WORD_W-1:0] word_nxt;
  logic [RW-1:0]     run_nxt;
  logic              smp;

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    bit_d       = bit_q;
    run_d       = run_q;
    div_d       = div_q;
    last_d      = last_q;
    part_d      = part_q;
    out_d       = out_q;
    valid_d     = valid_q;
    stop_seen_d = stop_seen_q;
    word_nxt    = {part_q, rnd_bit};
    run_nxt     = (rnd_bit == last_q && run_q != '0)
                ? run_q + RW'(1) : RW'(1);
    smp         = (div_q == DW'(SAMPLE_DIV - 1));

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = WARMUP;
          warm_d  = '0;
          bit_d   = '0;
          div_d   = '0;
          run_d   = '0;
          last_d  = 1'b0;
          part_d  = '0;
        end
      end
      WARMUP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (warm_q == WW'(WARMUP_CYC - 1)) begin
          state_d = COLLECT;
        end else begin
          warm_d = warm_q + WW'(1);
        end
      end
      COLLECT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (smp) begin
          div_d  = '0;
          part_d = word_nxt[WORD_W-2:0];
          run_d  = run_nxt;
          last_d = rnd_bit;
          bit_d  = bit_q + BW'(1);
          if (run_nxt == RW'(RCT_LIMIT)) begin
            state_d = FAIL;
          end else if (bit_q == BW'(WORD_W - 1)) begin
            state_d     = HOLD;
            out_d       = word_nxt;
            valid_d     = 1'b1;
            stop_seen_d = 1'b0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        if (valid_q && data_ready) begin
          valid_d = 1'b0;
          bit_d   = '0;
          div_d   = '0;
          state_d = (stop_seen_q || stop) ? IDLE : COLLECT;
        end else if (stop) begin
          stop_seen_d = 1'b1;
        end
      end
      FAIL: begin
        if (clear_fail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    en_d   = (state_d == WARMUP) || (state_d == COLLECT)
          || (state_d == HOLD);
    busy_d = en_d;
    fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      warm_q      <= '0;
      bit_q       <= '0;
      run_q       <= '0;
      div_q       <= '0;
      last_q      <= 1'b0;
      part_q      <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      stop_seen_q <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      bit_q       <= bit_d;
      run_q       <= run_d;
      div_q       <= div_d;
      last_q      <= last_d;
      part_q      <= part_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      stop_seen_q <= stop_seen_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
    end
  end

  assign trng_en     = en_q;
  assign data_out    = out_q;
  assign data_valid  = valid_q;
  assign busy        = busy_q;
  assign health_fail = fail_q;

endmodule
